// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants for the pipeline hazard/stall controller.
//   MUL_LAT_DEF  default multiplier latency (cycles after a mult leaves ID)
//   MUL_CNT_W    width of the multiplier-busy down-counter
//   ctrl_t       packed {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush}
//   CTRL_RUN / CTRL_STALL / CTRL_FLUSH  the three legal control encodings
package hazard_pkg;

  localparam int MUL_LAT_DEF = 4;
  localparam int MUL_CNT_W   = 4;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN   = 4'b1100;
  localparam ctrl_t CTRL_STALL = 4'b0001;
  localparam ctrl_t CTRL_FLUSH = 4'b1111;

endpackage

// File: rtl/hazard_unit_mul_busy_counter.sv
// mul_busy_counter: tracks how many cycles remain until HI/LO are valid.
//   clk, rst   clock, synchronous active-high reset
//   issue      a mult leaves ID this cycle; reload with MUL_LAT
//   mul_cnt    remaining latency (0 = HI/LO valid)
//   mul_busy   mul_cnt != 0
module mul_busy_counter
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue,
  output logic [MUL_CNT_W-1:0] mul_cnt,
  output logic                 mul_busy
);

  logic [MUL_CNT_W-1:0] mul_cnt_d, mul_cnt_q;

  // Issue takes precedence over decrement: a back-to-back mult can only
  // issue once the counter is already 0, but the ordering keeps it explicit.
  always_comb begin
    mul_cnt_d = mul_cnt_q;
    if (issue)                 mul_cnt_d = MUL_CNT_W'(MUL_LAT);
    else if (mul_cnt_q != '0)  mul_cnt_d = mul_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) mul_cnt_q <= '0;
    else     mul_cnt_q <= mul_cnt_d;
  end

  assign mul_cnt  = mul_cnt_q;
  assign mul_busy = (mul_cnt_q != '0);

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush controller for the 5-stage pipeline.
//   Inputs : ID-stage sources (IF_ID_Rs/Rt, ID_uses_Rt, ID_is_mult,
//            ID_is_mfhilo), EX-stage load info (ID_EX_MemRead, ID_EX_Rt),
//            EX_branch_taken.
//   Outputs: PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush (combinational),
//            mul_busy, stall_count (saturating count of stall cycles).
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             ID_uses_Rt,
  input  logic             ID_is_mult,
  input  logic             ID_is_mfhilo,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Rt,
  input  logic             EX_branch_taken,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             mul_busy,
  output logic [CNT_W-1:0] stall_count
);

  logic [MUL_CNT_W-1:0] mul_cnt;
  logic                 load_use, mul_hz, stall, mult_issue;
  ctrl_t                ctrl;
  logic [CNT_W-1:0]     stall_count_d, stall_count_q;

  always_comb begin
    // $0 is never a real producer, so a load into it cannot create a hazard.
    load_use = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
               ((ID_EX_Rt == IF_ID_Rs) || (ID_uses_Rt && (ID_EX_Rt == IF_ID_Rt)));
    // A second mult also waits so it cannot clobber a pending HI/LO.
    mul_hz   = (mul_cnt != '0) && (ID_is_mfhilo || ID_is_mult);
    // The ID instruction is wrong-path under a taken branch: never stall it.
    stall    = (load_use || mul_hz) && !EX_branch_taken;
    mult_issue = ID_is_mult && !stall && !EX_branch_taken;

    ctrl = CTRL_RUN;
    if (EX_branch_taken) ctrl = CTRL_FLUSH;
    else if (stall)      ctrl = CTRL_STALL;
  end

  assign PC_write    = ctrl.pc_write;
  assign IF_ID_write = ctrl.if_id_write;
  assign IF_ID_flush = ctrl.if_id_flush;
  assign ID_EX_flush = ctrl.id_ex_flush;

  mul_busy_counter #(.MUL_LAT(MUL_LAT)) u_mul_cnt (
    .clk      (clk),
    .rst      (rst),
    .issue    (mult_issue),
    .mul_cnt  (mul_cnt),
    .mul_busy (mul_busy)
  );

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) stall_count_d = stall_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_count_q <= '0;
    else     stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;

endmodule
